// File: rtl/axil_regbank_if.sv
// AXI4-Lite channel bundle for axil_regbank.
// The slave modport is what the register bank sees; master is the interconnect side.
interface axil_regbank_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Every channel uses standard AXI valid/ready: a beat transfers on a rising
    // clk edge where valid and ready are both 1. A source holds valid and its
    // payload stable until that edge, and a sink may drive ready independently of valid.
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );
endinterface

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank.
// The bank has NUM_REGS RW data registers, each with a hardware load port.
// It also has a W1C interrupt status register, an interrupt enable register and a read-only INFO word.
// Optional macro REGBANK_SLVERR_EN: return SLVERR for unmapped accesses and for writes to INFO.
// When the macro is undefined, both response channels are tied to OKAY.
module axil_regbank #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter int                STRB_W    = DATA_W / 8,
    parameter int                NUM_REGS  = 8,
    parameter int                NUM_IRQ   = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    axil_regbank_if.slave              s_axil,
    input  logic [NUM_REGS-1:0]        hw_en,
    input  logic [NUM_REGS*DATA_W-1:0] hw_in,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    input  logic [NUM_IRQ-1:0]         irq_set,
    output logic                       irq,
    output logic [1:0]                 dbg_rd_state
);
    // Decoding works on 32-bit word indices; address bits [1:0] are ignored.
    localparam int                WORD_W    = ADDR_W - 2;
    localparam logic [WORD_W-1:0] WORD_STAT = WORD_W'(32'h80);  // 0x200
    localparam logic [WORD_W-1:0] WORD_EN   = WORD_W'(32'h81);  // 0x204
    localparam logic [WORD_W-1:0] WORD_INFO = WORD_W'(32'h82);  // 0x208
    localparam logic [7:0]        NR8       = 8'(NUM_REGS);
    localparam logic [7:0]        NI8       = 8'(NUM_IRQ);
    localparam logic [DATA_W-1:0] INFO_VAL  = DATA_W'({NI8, NR8});

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_PEND = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

    // ---------------- write channel ----------------
    logic              r_aw_held;
    logic              r_w_held;
    logic              r_bvalid;
    logic [WORD_W-1:0] r_aw_word;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              w_wr_fire;
    logic              w_b_done;
    logic [DATA_W-1:0] w_wmask;
    logic [DATA_W-1:0] w_wbits;
    logic              w_hit_stat;
    logic              w_hit_en;

    assign w_wr_fire = r_aw_held & r_w_held & ~r_bvalid;
    assign w_b_done  = r_bvalid & s_axil.bready;

    assign s_axil.awready = ~r_aw_held;
    assign s_axil.wready  = ~r_w_held;
    assign s_axil.bvalid  = r_bvalid;

    // Hold each write beat until its response completes; bvalid rises at the commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_aw_word <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (s_axil.awvalid && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_aw_word <= s_axil.awaddr[ADDR_W-1:2];
            end else if (w_b_done) begin
                r_aw_held <= 1'b0;
            end
            if (s_axil.wvalid && !r_w_held) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axil.wdata;
                r_wstrb  <= s_axil.wstrb;
            end else if (w_b_done) begin
                r_w_held <= 1'b0;
            end
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (w_b_done) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Expand byte strobes into a bit mask for the held write beat.
    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            w_wmask[b*8 +: 8] = {8{r_wstrb[b]}};
        end
    end

    assign w_wbits    = r_wdata & w_wmask;
    assign w_hit_stat = w_wr_fire && (r_aw_word == WORD_STAT);
    assign w_hit_en   = w_wr_fire && (r_aw_word == WORD_EN);

    // ---------------- data registers ----------------
    logic [DATA_W-1:0] r_data [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_data
        // An AXI write wins over a hardware load; unwritten lanes keep the old value.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data[gi] <= RESET_VAL;
            end else if (w_wr_fire && (r_aw_word == WORD_W'(gi))) begin
                r_data[gi] <= (r_data[gi] & ~w_wmask) | w_wbits;
            end else if (hw_en[gi]) begin
                r_data[gi] <= hw_in[gi*DATA_W +: DATA_W];
            end
        end
        assign reg_out[gi*DATA_W +: DATA_W] = r_data[gi];
    end

    // ---------------- interrupts ----------------
    logic [NUM_IRQ-1:0] r_int_stat;
    logic [NUM_IRQ-1:0] r_int_en;
    logic               r_irq;
    logic [NUM_IRQ-1:0] w_w1c;

    assign w_w1c = w_hit_stat ? w_wbits[NUM_IRQ-1:0] : '0;

    // Status bits: a new set pulse beats a simultaneous W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_stat <= '0;
        end else begin
            r_int_stat <= (r_int_stat & ~w_w1c) | irq_set;
        end
    end

    // Enable register and the registered level interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_hit_en) begin
                r_int_en <= (r_int_en & ~w_wmask[NUM_IRQ-1:0]) | w_wbits[NUM_IRQ-1:0];
            end
            r_irq <= |(r_int_stat & r_int_en);
        end
    end

    assign irq = r_irq;

    // ---------------- read channel ----------------
    rd_state_t         r_rd_state;
    rd_state_t         w_rd_next;
    logic              w_arready;
    logic              w_rvalid;
    logic              w_rd_load;
    logic [WORD_W-1:0] r_ar_word;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rd_val;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    // Read FSM next state: accept, spend one cycle fetching, then hold until rready.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (s_axil.arvalid) w_rd_next = RD_PEND;
            RD_PEND: w_rd_next = RD_RESP;
            RD_RESP: if (s_axil.rready) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        w_rd_load = 1'b0;
        case (r_rd_state)
            RD_IDLE: w_arready = 1'b1;
            RD_PEND: w_rd_load = 1'b1;
            RD_RESP: w_rvalid  = 1'b1;
            default: w_arready = 1'b0;
        endcase
    end

    assign s_axil.arready = w_arready;
    assign s_axil.rvalid  = w_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign dbg_rd_state   = r_rd_state;

    // Read mux; unmapped words read as zero.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_ar_word == WORD_W'(i)) w_rd_val = r_data[i];
        end
        if (r_ar_word == WORD_STAT) w_rd_val = DATA_W'(r_int_stat);
        if (r_ar_word == WORD_EN)   w_rd_val = DATA_W'(r_int_en);
        if (r_ar_word == WORD_INFO) w_rd_val = INFO_VAL;
    end

    // Capture the read address at accept and register the data one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar_word <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_arready && s_axil.arvalid) r_ar_word <= s_axil.araddr[ADDR_W-1:2];
            if (w_rd_load) r_rdata <= w_rd_val;
        end
    end

    // ---------------- responses ----------------
`ifdef REGBANK_SLVERR_EN
    logic [1:0] r_bresp;
    logic [1:0] r_rresp;
    logic       w_wr_ok;
    logic       w_rd_ok;

    assign w_wr_ok = (r_aw_word < WORD_W'(NUM_REGS)) || (r_aw_word == WORD_STAT) ||
                     (r_aw_word == WORD_EN);
    assign w_rd_ok = (r_ar_word < WORD_W'(NUM_REGS)) || (r_ar_word == WORD_STAT) ||
                     (r_ar_word == WORD_EN) || (r_ar_word == WORD_INFO);

    // Responses are latched at commit/fetch, so they stay stable while valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bresp <= 2'b00;
            r_rresp <= 2'b00;
        end else begin
            if (w_wr_fire) r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
            if (w_rd_load) r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
        end
    end

    assign s_axil.bresp = r_bresp;
    assign s_axil.rresp = r_rresp;
`else
    assign s_axil.bresp = 2'b00;
    assign s_axil.rresp = 2'b00;
`endif

    // Protection bits and byte offsets carry no meaning for this bank.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, s_axil.awprot, s_axil.arprot,
                           s_axil.awaddr[1:0], s_axil.araddr[1:0]};
endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank: table vectors, directed corner sequences
// and randomized traffic compared against a behavioural register model.
module tb_axil_regbank;
    localparam int NR = 8;
    localparam int NI = 8;
    localparam int AW = 16;
    localparam int DW = 32;
`ifdef REGBANK_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [NR-1:0]    hw_en;
    logic [NR*DW-1:0] hw_in;
    logic [NR*DW-1:0] reg_out;
    logic [NI-1:0]    irq_set;
    logic             irq;
    logic [1:0]       dbg_rd_state;

    axil_regbank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .NUM_IRQ(NI)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axil       (bus),
        .hw_en        (hw_en),
        .hw_in        (hw_in),
        .reg_out      (reg_out),
        .irq_set      (irq_set),
        .irq          (irq),
        .dbg_rd_state (dbg_rd_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [31:0]   m_data [NR];
    logic [NI-1:0] m_stat;
    logic [NI-1:0] m_en;
    logic [31:0]   exp_q[$];
    logic [1:0]    exp_resp_q[$];

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic bit is_data(input logic [15:0] a);
        return int'(a) / 4 < NR;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        int w = int'(a) & 32'hFFFC;
        if (is_data(a)) return m_data[w / 4];
        if (w == 32'h200) return 32'(m_stat);
        if (w == 32'h204) return 32'(m_en);
        if (w == 32'h208) return (NI << 8) + NR;
        return 32'h0;
    endfunction

    function automatic logic [1:0] model_rd_resp(input logic [15:0] a);
        int w = int'(a) & 32'hFFFC;
        if (is_data(a) || w == 32'h200 || w == 32'h204 || w == 32'h208) return 2'b00;
        return ERR;
    endfunction

    function automatic logic [1:0] model_wr_resp(input logic [15:0] a);
        int w = int'(a) & 32'hFFFC;
        if (is_data(a) || w == 32'h200 || w == 32'h204) return 2'b00;
        return ERR;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int w = int'(a) & 32'hFFFC;
        logic [31:0] m = strb_mask(s);
        if (is_data(a)) m_data[w / 4] = (m_data[w / 4] & ~m) | (d & m);
        else if (w == 32'h200) m_stat = m_stat & ~NI'(d & m);
        else if (w == 32'h204) m_en = (m_en & ~NI'(m)) | NI'(d & m);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_regs(input string name);
        for (int i = 0; i < NR; i++) check(name, reg_out[i*DW +: DW], m_data[i]);
    endtask

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_hs, w_hs, b_hs, done;
        done = 0;
        resp = 2'b11;
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = a;
        bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
        bus.bready  = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bvalid && bus.bready;
            if (b_hs) resp = bus.bresp;
            @(negedge clk);
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs) bus.wvalid = 1'b0;
            if (b_hs) done = 1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        check("wr_complete", 32'(done), 32'd1);
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_hs, r_hs, done;
        done = 0;
        d = '0;
        resp = 2'b11;
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid && bus.rready;
            if (r_hs) begin d = bus.rdata; resp = bus.rresp; end
            @(negedge clk);
            if (ar_hs) bus.arvalid = 1'b0;
            if (r_hs) done = 1;
        end
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        check("rd_complete", 32'(done), 32'd1);
    endtask

    // Write whose commit edge coincides with the given hw_en/hw_in/irq_set values.
    task automatic write_with_side(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                                   input logic [NR-1:0] hen, input logic [NR*DW-1:0] hin,
                                   input logic [NI-1:0] iset, output logic [1:0] resp);
        @(negedge clk);
        check("side_ready", 32'({bus.awready, bus.wready}), 32'd3);
        bus.awvalid = 1'b1; bus.awaddr = a;
        bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
        bus.bready  = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        hw_en = hen; hw_in = hin; irq_set = iset;
        @(negedge clk);
        hw_en = '0; irq_set = '0;
        check("side_bvalid", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        exp_q.push_back(model_read(a));
        exp_resp_q.push_back(model_rd_resp(a));
        axi_read(a, d, r);
        check(name, d, exp_q.pop_front());
        check({name, "_resp"}, 32'(r), 32'(exp_resp_q.pop_front()));
    endtask

    // ---------------- stimulus ----------------
    vec_t             tbl [16];
    logic [31:0]      rd_d;
    logic [1:0]       rsp;
    logic [NR*DW-1:0] hin_v;
    logic [15:0]      a;
    logic [31:0]      d;
    logic [3:0]       s;
    int               idx;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0; bus.rready = 0;
        hw_en = '0; hw_in = '0; irq_set = '0;
        for (int i = 0; i < NR; i++) m_data[i] = 32'h0;
        m_stat = '0; m_en = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of the handshake and status outputs.
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_wready", 32'(bus.wready), 32'd1);
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_bresp", 32'(bus.bresp), 32'd0);
        check("rst_rresp", 32'(bus.rresp), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check_all_regs("rst_reg_out");

        // Table vectors: reset readback, strobed write, ignored low address bits, unmapped.
        for (int i = 0; i < NR; i++) tbl[i] = '{1'b0, 16'(4 * i), 32'h0, 4'h0, 32'h0, 2'b00};
        tbl[8]  = '{1'b0, 16'h200, 32'h0, 4'h0, 32'h0, 2'b00};
        tbl[9]  = '{1'b0, 16'h204, 32'h0, 4'h0, 32'h0, 2'b00};
        tbl[10] = '{1'b0, 16'h208, 32'h0, 4'h0, 32'h0000_0808, 2'b00};
        tbl[11] = '{1'b1, 16'h01C, 32'h1234_5678, 4'h5, 32'h0, 2'b00};
        tbl[12] = '{1'b0, 16'h01C, 32'h0, 4'h0, 32'h0034_0078, 2'b00};
        tbl[13] = '{1'b0, 16'h01E, 32'h0, 4'h0, 32'h0034_0078, 2'b00};
        tbl[14] = '{1'b1, 16'h20C, 32'hFFFF_FFFF, 4'hF, 32'h0, ERR};
        tbl[15] = '{1'b0, 16'h20C, 32'h0, 4'h0, 32'h0, ERR};
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, rsp);
                check($sformatf("tbl%0d_bresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
                model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            end else begin
                axi_read(tbl[i].addr, rd_d, rsp);
                check($sformatf("tbl%0d_rdata", i), rd_d, tbl[i].exp_rdata);
                check($sformatf("tbl%0d_rresp", i), 32'(rsp), 32'(tbl[i].exp_resp));
            end
        end

        // AW leads W by three cycles; bvalid one cycle after W accept.
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 16'h004; bus.bready = 1'b0;
        check("aw_lead_awready", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        check("aw_held_awready", 32'(bus.awready), 32'd0);
        repeat (2) @(negedge clk);
        bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
        check("w_late_wready", 32'(bus.wready), 32'd1);
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("b_not_early", 32'(bus.bvalid), 32'd0);
        @(negedge clk);
        check("b_after_w", 32'(bus.bvalid), 32'd1);
        check("b_okay", 32'(bus.bresp), 32'd0);
        check("reg1_deadbeef", reg_out[63:32], 32'hDEAD_BEEF);
        model_write(16'h004, 32'hDEAD_BEEF, 4'hF);

        // bready held low: a second write must be neither accepted nor committed.
        bus.awvalid = 1'b1; bus.awaddr = 16'h004;
        bus.wvalid = 1'b1; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bstall_awready", 32'(bus.awready), 32'd0);
            check("bstall_wready", 32'(bus.wready), 32'd0);
            check("bstall_bvalid", 32'(bus.bvalid), 32'd1);
            check("bstall_bresp", 32'(bus.bresp), 32'd0);
            check("bstall_reg1", reg_out[63:32], 32'hDEAD_BEEF);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bdone_bvalid", 32'(bus.bvalid), 32'd0);
        check("bdone_awready", 32'(bus.awready), 32'd1);
        read_check("rb_reg1", 16'h004);

        // Partial-strobe write colliding with a hardware load on the same register.
        hin_v = '0;
        hin_v[2*DW +: DW] = 32'h1111_1111;
        write_with_side(16'h008, 32'hAABB_CCDD, 4'h3, NR'(4), hin_v, '0, rsp);
        check("hwcol_bresp", 32'(rsp), 32'd0);
        check("hwcol_reg2", reg_out[95:64], 32'h0000_CCDD);
        model_write(16'h008, 32'hAABB_CCDD, 4'h3);
        read_check("hwcol_rb", 16'h008);

        // Interrupts: enable, set, irq two cycles after the pulse, W1C races, clear.
        axi_write(16'h204, 32'h5, 4'hF, rsp);
        model_write(16'h204, 32'h5, 4'hF);
        @(negedge clk);
        irq_set = NI'(7);
        @(negedge clk);
        irq_set = '0;
        m_stat = m_stat | NI'(7);
        check("irq_lat1", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_lat2", 32'(irq), 32'd1);
        read_check("stat_set", 16'h200);
        write_with_side(16'h200, 32'h1, 4'hF, '0, '0, NI'(1), rsp);
        read_check("stat_set_wins", 16'h200);
        check("irq_still", 32'(irq), 32'd1);
        axi_write(16'h200, 32'h5, 4'hF, rsp);
        model_write(16'h200, 32'h5, 4'hF);
        check("irq_cleared", 32'(irq), 32'd0);
        read_check("stat_after_w1c", 16'h200);

        // Read with rready low: response held, arready low throughout.
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = 16'h004; bus.rready = 1'b0;
        check("ar_ready", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("r_not_early", 32'(bus.rvalid), 32'd0);
        @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            check("rstall_rvalid", 32'(bus.rvalid), 32'd1);
            check("rstall_rdata", bus.rdata, 32'hDEAD_BEEF);
            check("rstall_arready", 32'(bus.arready), 32'd0);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("rdone_rvalid", 32'(bus.rvalid), 32'd0);
        check("rdone_arready", 32'(bus.arready), 32'd1);

        // Unmapped read and INFO write.
        read_check("unmapped_rd", 16'h300);
        axi_write(16'h208, 32'hFFFF_FFFF, 4'hF, rsp);
        check("info_wr_bresp", 32'(rsp), 32'(ERR));
        read_check("info_kept", 16'h208);

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    idx = $urandom_range(0, NR - 1);
                    a = 16'(4 * idx + $urandom_range(0, 3));
                    d = $urandom;
                    s = 4'($urandom_range(0, 15));
                    axi_write(a, d, s, rsp);
                    check("rnd_data_bresp", 32'(rsp), 32'(model_wr_resp(a)));
                    model_write(a, d, s);
                end
                1: begin
                    case ($urandom_range(0, 4))
                        0: a = 16'(4 * $urandom_range(0, NR - 1));
                        1: a = 16'h200;
                        2: a = 16'h204;
                        3: a = 16'h208;
                        default: a = 16'(32'h220 + 4 * $urandom_range(0, 40));
                    endcase
                    read_check("rnd_rd", a);
                end
                2: begin
                    idx = $urandom_range(0, NR - 1);
                    d = $urandom;
                    @(negedge clk);
                    hw_en[idx] = 1'b1;
                    hw_in[idx*DW +: DW] = d;
                    @(negedge clk);
                    hw_en = '0;
                    m_data[idx] = d;
                end
                3: begin
                    @(negedge clk);
                    irq_set = NI'($urandom);
                    m_stat = m_stat | irq_set;
                    @(negedge clk);
                    irq_set = '0;
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 16'h200;
                        1: a = 16'h204;
                        2: a = 16'h208;
                        default: a = 16'h240;
                    endcase
                    d = $urandom;
                    s = 4'($urandom_range(0, 15));
                    axi_write(a, d, s, rsp);
                    check("rnd_ctl_bresp", 32'(rsp), 32'(model_wr_resp(a)));
                    model_write(a, d, s);
                end
            endcase
            @(negedge clk);
            check("rnd_irq", 32'(irq), 32'(|(m_stat & m_en)));
            check_all_regs("rnd_reg_out");
        end
        read_check("final_stat", 16'h200);
        read_check("final_en", 16'h204);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_regbank.md
Name: axil_regbank

Overview:
Parametrised AXI4-Lite register bank that replaces per-map generated register files for simple control/status blocks. It provides NUM_REGS read/write data registers, each with a hardware load port, plus an interrupt status/enable pair with W1C semantics and a single level interrupt output. It sits between the AXI-Lite interconnect and the user datapath.

Parameters:
ADDR_W, 16, AXI address width
DATA_W, 32, AXI data width; only 32 is supported
STRB_W, DATA_W/8, write strobe width
NUM_REGS, 8, number of RW data registers (1..64)
NUM_IRQ, 8, number of interrupt sources (1..32)
RESET_VAL, 0, reset value of every data register (DATA_W bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hw_en  in  NUM_REGS  per-register hardware load enable
hw_in  in  NUM_REGS*DATA_W  hardware load data; register i uses slice [i*DATA_W +: DATA_W]
reg_out  out  NUM_REGS*DATA_W  current value of every data register, same packing as hw_in
irq_set  in  NUM_IRQ  single-cycle interrupt set pulses
irq  out  1  registered interrupt request
axil_aw*/w*/b*/ar*/r*  AXI4-Lite slave channels; full set with prot inputs, which are ignored

Behaviour:
- Address map (byte address; bits [1:0] ignored):
  - 0x000 + 4*i: DATA[i] for i < NUM_REGS.
  - 0x200: INT_STAT. NUM_IRQ bits, W1C, RO to hardware.
  - 0x204: INT_EN. NUM_IRQ bits, RW.
  - 0x208: INFO, RO. Bits [7:0] = NUM_REGS, bits [15:8] = NUM_IRQ.
  - Any other address is unmapped.
- Reset state:
  - awready, wready and arready = 1.
  - bvalid = 0, rvalid = 0, rdata = 0, bresp = 0, rresp = 0, irq = 0.
  - DATA = RESET_VAL; INT_STAT = 0; INT_EN = 0.
- Write channel:
  - AW and W are accepted independently; each is captured when valid && ready.
  - awready/wready deassert while the respective beat is held.
  - The write executes on the first cycle in which both beats are held and bvalid = 0.
  - Registers update at that clock edge, and bvalid rises at the same edge.
  - Latency: AW and W presented together on edge N -> write commits and bvalid is seen after edge N+1.
  - Both ready signals reassert once bvalid && bready completes.
  - bresp is held stable while bvalid = 1.
- Byte strobes apply to DATA, INT_EN and INT_STAT.
  - INT_STAT clears only bits that are written 1 within enabled byte lanes.
- Read channel:
  - arready = ~(pending || rvalid).
  - AR accepted on edge N -> rvalid = 1 with registered rdata after edge N+1.
  - rdata/rresp are held until rready; arready returns the cycle after the handshake.
- Data register priority, per register:
  - AXI write > hw_en load > hold.
  - A software write with partial strobes in the same cycle as hw_en: written lanes take wdata; unwritten lanes keep the old value, not hw_in.
- INT_STAT bit update:
  - next = (cur & ~w1c_mask) | irq_set.
  - Set wins over a simultaneous clear.
- irq = registered |(INT_STAT & INT_EN).
  - irq_set at edge N -> INT_STAT bit set after edge N -> irq high after edge N+1.
- Unmapped accesses:
  - Reads return 0 with OKAY; writes are discarded with OKAY (see optional feature).
  - Writes to INFO are discarded with OKAY.
- Reset mid-transaction: all held beats and valids are dropped and registers return to reset values; no response is issued for the in-flight transaction.

Optional Feature:
REGBANK_SLVERR_EN
- Defined: reads and writes to unmapped addresses, and writes to INFO, return SLVERR (2'b10) on rresp/bresp. Read data is 0; no register changes.
- Not defined: bresp/rresp are tied to OKAY (2'b00), and no decode-error logic is generated.

Test Plan:
1. Reset, then read DATA[0..NUM_REGS-1], INT_STAT, INT_EN, INFO -> RESET_VAL, 0, 0, 0x0808; rresp = 0 on every read.
2. Write 0xDEADBEEF, wstrb = 0xF, to 0x004 with AW presented 3 cycles before W -> bvalid one cycle after W accept; reg_out[63:32] = 0xDEADBEEF; readback matches.
3. Same cycle: hw_en[2] = 1 with hw_in = 0x11111111, and AXI write to 0x008 of 0xAABBCCDD with wstrb = 0x3 (prior value 0) -> DATA[2] = 0x0000CCDD.
4. Write INT_EN = 0x05, then pulse irq_set = 0x07 -> INT_STAT = 0x07 and irq = 1 two cycles after the pulse. W1C 0x01 in the same cycle as irq_set[0] pulses -> bit 0 stays 1. W1C 0x05 -> irq = 0 next cycle.
5. Read with rready held low for 10 cycles -> rvalid and rdata stable, arready = 0 throughout. Write with bready held low -> awready/wready stay 0 and no second write commits.
6. Read of 0x300 and write of 0x208 -> with REGBANK_SLVERR_EN: rresp = bresp = 2'b10, rdata = 0, INFO unchanged. Without it: both responses 2'b00.
